// File: rtl/unidad_logica_secuencial.sv
// Registered stream reducer: folds WIDTH-bit operands with a selectable logic function
// and hands the result (count, error flag) to a consumer through a valid/ready handshake.
module unidad_logica_secuencial #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_OPS = 16,
  localparam int unsigned CW     = $clog2(MAX_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             act,
  input  logic [2:0]       sel,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             err
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACUM   = 2'd1;
  localparam logic [1:0] SALIDA = 2'd2;

  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OPS);

  logic [1:0]       state_q, state_d;
  logic [2:0]       sel_q, sel_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CW-1:0]    out_count_q, out_count_d;
  logic             err_q, err_d;

  logic             fire_in, fire_out;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] folded, nxt_acc, result;
  logic [CW-1:0]    nxt_cnt;
  logic             sel_bad, forced, close;

  // Handshake flags depend only on state, act and reset, never on the peer's strobes.
  assign in_ready  = rst_n & act & ((state_q == IDLE) | (state_q == ACUM));
  assign out_valid = (state_q == SALIDA);
  assign fire_in   = in_valid & in_ready;
  assign fire_out  = out_valid & out_ready & act;

  assign out_data  = out_data_q;
  assign out_count = out_count_q;
  assign err       = err_q;

  // The first beat of a frame uses the live select; later beats use the latched one.
  always_comb begin
    op_sel = (state_q == IDLE) ? sel : sel_q;
    case (op_sel)
      3'b001, 3'b100: folded = acc_q & in_data;
      3'b010, 3'b101: folded = acc_q | in_data;
      3'b011, 3'b110: folded = acc_q ^ in_data;
      default:        folded = acc_q;
    endcase
    nxt_acc = (state_q == IDLE) ? in_data : folded;
    nxt_cnt = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);
    sel_bad = (op_sel == 3'b000) || (op_sel == 3'b111);
    forced  = !in_last && (nxt_cnt == MAX_CNT);
    close   = in_last || (nxt_cnt == MAX_CNT);
    result  = sel_bad ? '0 : (op_sel[2] ? ~nxt_acc : nxt_acc);
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    err_d       = err_q;
    if (fire_in) begin
      acc_d = nxt_acc;
      cnt_d = nxt_cnt;
      if (state_q == IDLE) begin
        sel_d = sel;
      end
      if (close) begin
        state_d     = SALIDA;
        out_data_d  = result;
        out_count_d = nxt_cnt;
        err_d       = sel_bad | forced;
      end else begin
        state_d = ACUM;
      end
    end else if (fire_out) begin
      state_d = IDLE;
    end else if (state_q == 2'd3) begin
      state_d = IDLE;
    end
  end

  // Reset wins over act; with act low every next-state equals the current state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= 3'b000;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_count_q <= '0;
      err_q       <= 1'b0;
    end else if (act) begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_unidad_logica_secuencial.sv
// Scoreboard bench for unidad_logica_secuencial: a list-folding reference model queues
// expected results, an independent monitor compares them against the DUT output port.
module tb_unidad_logica_secuencial;

  localparam int unsigned W      = 8;
  localparam int unsigned MAXOPS = 16;
  localparam int unsigned CW     = $clog2(MAXOPS + 1);

  typedef struct packed {
    logic [W-1:0]  data;
    logic [CW-1:0] count;
    logic          err;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_n, act, in_valid, in_ready, in_last, out_valid, out_ready, err;
  logic [2:0]    sel;
  logic [W-1:0]  in_data, out_data;
  logic [CW-1:0] out_count;

  res_t          exp_q[$];
  logic [W-1:0]  beats[$];
  logic [2:0]    frame_sel;
  int            n_checks = 0;
  int            n_pass = 0;
  logic          rand_en = 1'b0;

  unidad_logica_secuencial #(
    .WIDTH  (W),
    .MAX_OPS(MAXOPS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .act      (act),
    .sel      (sel),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, got, want, $time);
  endtask

  // Reference: fold the frame's beat list with the named function, invert N-variants.
  function automatic res_t model(input logic [2:0] s, input logic forced);
    res_t         o;
    logic [W-1:0] r;
    r = beats[0];
    for (int i = 1; i < beats.size(); i++) begin
      if (s == 3'd1 || s == 3'd4)      r = r & beats[i];
      else if (s == 3'd2 || s == 3'd5) r = r | beats[i];
      else                             r = r ^ beats[i];
    end
    if (s >= 3'd4) r = ~r;
    if (s == 3'd0 || s == 3'd7) r = '0;
    o.data  = r;
    o.count = CW'(beats.size());
    o.err   = forced || s == 3'd0 || s == 3'd7;
    return o;
  endfunction

  // Model: decides acceptance from its own view (no result pending), pushes after the monitor.
  initial begin
    forever begin
      res_t staged;
      logic have;
      @(negedge clk);
      #1;
      have = 1'b0;
      if (rst_n && act && in_valid && exp_q.size() == 0) begin
        if (beats.size() == 0) frame_sel = sel;
        beats.push_back(in_data);
        if (in_last || beats.size() == MAXOPS) begin
          staged = model(frame_sel, !in_last);
          have   = 1'b1;
          beats.delete();
        end
      end
      #3;
      if (!rst_n) begin
        exp_q.delete();
        beats.delete();
      end else if (have) begin
        exp_q.push_back(staged);
      end
    end
  end

  // Monitor: a queued result means out_valid must be high and in_ready low.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      check("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(rst_n && act && exp_q.size() == 0));
      if (exp_q.size() != 0 && out_valid) begin
        check("out_data", 32'(out_data), 32'(exp_q[0].data));
        check("out_count", 32'(out_count), 32'(exp_q[0].count));
        check("err", 32'(err), 32'(exp_q[0].err));
        if (rst_n && act && out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rand_en) begin
        out_ready = ($urandom_range(0, 3) != 0);
        act       = ($urandom_range(0, 7) != 0);
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic last, input logic [2:0] s);
    int   guard;
    logic done;
    guard = 0;
    done  = 1'b0;
    while (!done) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      sel      = s;
      #2;
      if (in_ready) begin
        done = 1'b1;
      end else if (++guard > 300) begin
        n_checks++;
        $display("FAIL send_timeout: in_ready stayed 0, required 1 (t=%0t)", $time);
        done = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; act = 1'b1; sel = 3'b000; in_valid = 1'b0;
    in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_in_ready", 32'(in_ready), 32'd0);
    check("init_out_data", 32'(out_data), 32'd0);
    rst_n = 1'b1;

    // AND frame
    send(8'hF0, 1'b0, 3'b001); send(8'h3C, 1'b0, 3'b001); send(8'hFF, 1'b1, 3'b001);
    idle(3);
    // XNOR frame, select changed mid-frame
    send(8'hAA, 1'b0, 3'b110); send(8'h0F, 1'b1, 3'b001);
    idle(3);
    // Forced close after MAX_OPS beats, the 17th beat forms its own frame
    for (int i = 1; i <= 17; i++) send(8'h01, i == 17, 3'b010);
    idle(3);
    // Invalid select under backpressure, in_valid kept high
    out_ready = 1'b0;
    send(8'h5A, 1'b0, 3'b111); send(8'hC3, 1'b1, 3'b111);
    repeat (6) begin
      @(negedge clk);
      in_valid = 1'b1; in_last = 1'b1; in_data = 8'h77; sel = 3'b001;
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    idle(2);
    // Enable freeze mid-frame
    send(8'hFF, 1'b0, 3'b001);
    repeat (4) begin
      @(negedge clk);
      act = 1'b0; in_valid = 1'b1; in_data = 8'h00; in_last = 1'b1;
    end
    act = 1'b1;
    send(8'h0F, 1'b0, 3'b001); send(8'h3F, 1'b1, 3'b001);
    // Freeze while the result is presented
    send(8'h55, 1'b1, 3'b011);
    repeat (3) begin
      @(negedge clk);
      act = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    end
    @(negedge clk);
    act = 1'b1;
    idle(2);
    // Reset mid-frame, then mid-output
    send(8'h12, 1'b0, 3'b010);
    reset_pulse();
    out_ready = 1'b0;
    send(8'h34, 1'b1, 3'b001);
    idle(2);
    reset_pulse();
    out_ready = 1'b1;
    send(8'h00, 1'b1, 3'b101);
    idle(3);

    // Randomized frames with random act and out_ready
    rand_en = 1'b1;
    for (int f = 0; f < 40; f++) begin
      int          len;
      logic [2:0]  s;
      len = $urandom_range(1, 19);
      s   = 3'($urandom_range(0, 7));
      for (int b = 1; b <= len; b++) send(8'($urandom), b == len, s);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(1);
    rand_en = 1'b0;
    @(negedge clk);
    act = 1'b1; out_ready = 1'b1;
    idle(2);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/unidad_logica_secuencial.md
# unidad_logica_secuencial

Parametrised, registered successor of the 3-input gate selector. Reduces a stream of WIDTH-bit operands, one per accepted beat, with the selected logic function (AND, OR, XOR, NAND, NOR, XNOR). The result is held for a downstream consumer through a valid/ready handshake. It sits between an operand source and any consumer in the logic-function datapath, and keeps the global enable (`act`) and the 3-bit select encoding of the existing gate blocks.

## Interface
- `WIDTH`, 8: operand and result width in bits (≥1).
- `MAX_OPS`, 16: maximum beats per frame (≥2). The derived local `CW = $clog2(MAX_OPS+1)` sets the width of the beat count.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: reset is synchronous and active-low.
- `act` in 1: global enable; low freezes the block.
- `sel` in 3: function select, sampled on the first beat of a frame only. 001 AND, 010 OR, 011 XOR, 100 NAND, 101 NOR, 110 XNOR; 000 and 111 are invalid.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block accepts a beat.
- `in_data` in WIDTH: operand.
- `in_last` in 1: marks the final beat of a frame.
- `out_valid` out 1: result available.
- `out_ready` in 1: consumer accepts the result.
- `out_data` out WIDTH: bitwise reduction result.
- `out_count` out CW: number of beats reduced into `out_data`.
- `err` out 1: result flag, valid with `out_valid`. Set on invalid `sel` or forced frame close.

## Operation
- A beat is accepted when `in_valid & in_ready`. A result is taken when `out_valid & out_ready & act`.
- FSM states:
  - IDLE. `in_ready = act`. On an accepted beat:
    - latch `sel` into `sel_q`;
    - set `acc = in_data` and `cnt = 1`;
    - if `in_last`, go to SALIDA; otherwise go to ACUM.
  - ACUM. `in_ready = act`. On an accepted beat:
    - update `acc = acc op in_data`, where op is AND for 001/100, OR for 010/101, XOR for 011/110;
    - increment `cnt`;
    - go to SALIDA if `in_last`, or if `cnt` reaches MAX_OPS without `in_last`.
  - SALIDA. `in_ready = 0` and `out_valid = 1`.
    - `out_data = acc` for 001/010/011 and `~acc` for 100/101/110.
    - `out_count = cnt`.
    - When the result is taken, go to IDLE.
- Invalid `sel_q` (000/111):
  - the frame is still consumed to `in_last` (or the MAX_OPS close);
  - the result has `out_data = 0` and `err = 1`.
- Forced close: the MAX_OPS-th beat without `in_last` closes the frame with `err = 1`. Later beats start a new frame.
- A single-beat frame gives `out_data = in_data`, or `~in_data` for the N-variants.
- Changes to `sel` in mid-frame are ignored.
- `act = 0`:
  - state, `acc`, `cnt` and outputs are frozen;
  - `in_ready = 0`;
  - `out_valid` keeps its value, but no output transfer completes whatever `out_ready` is.
- Reset (`rst_n` low at a clock edge), from any state including mid-frame or mid-output:
  - state IDLE;
  - `acc = 0`, `cnt = 0`;
  - `out_valid = 0`, `out_data = 0`, `out_count = 0`, `err = 0`;
  - `in_ready = 0` while `rst_n` is low.
  - The partial frame is discarded.

## Timing
- `in_ready` and `out_valid` are combinational from state and `act` only; there is no path from `in_valid` or `out_ready`.
- All data outputs are registered.
- Latency: `out_valid` rises one cycle after the last beat is accepted.
- A k-beat frame occupies k accepting cycles plus at least 1 SALIDA cycle. With `out_ready` held high, sustained throughput is one frame per k+1 cycles.
- Backpressure: `out_data`, `out_count` and `err` stay stable while `out_valid & !out_ready`.
- The next frame's first beat can be accepted in the cycle after the result is taken, not in the same cycle.
- Reset with `act = 0` still resets; reset has priority over `act`.

## Test plan
- AND frame, WIDTH=8, `sel=001`, beats 0xF0, 0x3C, 0xFF (last), `out_ready=1` → one cycle after the last beat: `out_valid=1`, `out_data=0x30`, `out_count=3`, `err=0`. `in_ready` is low for that cycle, then high.
- XNOR frame, `sel=110`, beats 0xAA, 0x0F (last), with `sel` changed to 001 on the second beat → `out_data=0x5A` (~(0xAA^0x0F)); the `sel` change is ignored.
- Forced close, MAX_OPS=16: 17 OR beats of 0x01 with `in_last` only on beat 17 → first result `out_count=16`, `err=1`, `out_data=0x01`. Second result `out_count=1`, `err=0`, `out_data=0x01`.
- Invalid select and backpressure: `sel=111`, 2 beats, `out_ready=0` for 5 cycles → `out_valid`, `out_data=0x00` and `err=1` held stable for all 5 cycles. `in_ready=0` throughout. Transfer completes on the first cycle `out_ready=1`.
- Enable freeze: drop `act` mid-frame after beat 1 of an AND frame for 4 cycles while driving `in_valid=1` → `in_ready=0` and no beats are counted. On resuming, the frame completes with the correct `out_count`.
- Reset mid-frame and mid-output: assert `rst_n=0` for 1 cycle in ACUM and again in SALIDA → next cycle all outputs are 0 and state is IDLE. A following single-beat NOR frame of 0x00 gives `out_data=0xFF` and `out_count=1`.
